// File: rtl/fetch_unit_s_if.sv
// Instruction memory request/response bundle for the fetch stage.
// master = fetch side, slave = memory side.
interface fetch_unit_s_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output rdata
   );
endinterface

// File: rtl/fetch_unit_s.sv
// Fetch stage: owns the PC, one outstanding imem request, stall/flush gating.
// Optional FETCH_PERF_EN adds fetch_count/bubble_count performance counters.
module fetch_unit_s #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           is_stall,
   input  logic           is_flush,
   input  logic [31:0]    flush_pc,
   fetch_unit_s_if.master imem,
   output logic           is_valid_out,
   output logic [31:0]    pc_out,
   output logic [31:0]    instr_out
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]    fetch_count,
   output logic [31:0]    bubble_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DRAIN
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] drain_addr;
   logic [31:0] hold_pc;
   logic [31:0] hold_instr;
   logic        deliver;

   assign imem.req  = (state == FETCH) || (state == DRAIN);
   assign imem.addr = (state == DRAIN) ? drain_addr : pc;

   // Asserted exactly when a new instruction is handed to IF/ID.
   assign deliver = !is_flush && !is_stall &&
                    ((state == FETCH && imem.ack) || state == HOLD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         drain_addr   <= '0;
         hold_pc      <= '0;
         hold_instr   <= '0;
         is_valid_out <= 1'b0;
         pc_out       <= '0;
         instr_out    <= '0;
      end else if (is_flush) begin
         is_valid_out <= 1'b0;
         hold_pc      <= '0;
         hold_instr   <= '0;
         pc           <= flush_pc;
         unique case (state)
            FETCH: begin
               if (imem.ack) begin
                  state <= FETCH;
               end else begin
                  drain_addr <= pc;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               if (imem.ack)
                  state <= FETCH;
            end
            HOLD:  state <= FETCH;
            IDLE:  state <= FETCH;
         endcase
      end else begin
         unique case (state)
            IDLE: begin
               is_valid_out <= 1'b0;
               state        <= FETCH;
            end
            FETCH: begin
               if (!imem.ack) begin
                  is_valid_out <= 1'b0;
               end else if (is_stall) begin
                  hold_pc      <= pc;
                  hold_instr   <= imem.rdata;
                  pc           <= pc + PC_STEP;
                  is_valid_out <= 1'b0;
                  state        <= HOLD;
               end else begin
                  is_valid_out <= 1'b1;
                  pc_out       <= pc;
                  instr_out    <= imem.rdata;
                  pc           <= pc + PC_STEP;
               end
            end
            HOLD: begin
               if (is_stall) begin
                  is_valid_out <= 1'b0;
               end else begin
                  is_valid_out <= 1'b1;
                  pc_out       <= hold_pc;
                  instr_out    <= hold_instr;
                  state        <= FETCH;
               end
            end
            DRAIN: begin
               is_valid_out <= 1'b0;
               if (imem.ack)
                  state <= FETCH;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (deliver)
            fetch_count <= fetch_count + 32'd1;
         if (!is_valid_out && state != IDLE)
            bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

endmodule
